mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port unified instruction/data memory between the core and a debug/loader port.
- The core request comes from the multi-cycle control FSM (FETCH, MEMADR/load/store states).
- The debug port preloads programs and inspects memory while the core runs.
- Issues at most one access per cycle to memory; returns read data with fixed 1-cycle latency to the requester that owned the access.

Parameters:
- ADDR_WIDTH, 32, byte address width passed through to memory.
- DATA_WIDTH, 32, data word width; byte enables are DATA_WIDTH/8 bits.
- MAX_LOCK, 8, max consecutive debug grants under d_lock before one forced core slot.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- c_req  in  1  core access request, held until c_gnt
- c_we  in  1  core write enable
- c_be  in  DATA_WIDTH/8  core byte enables (writes only)
- c_addr  in  ADDR_WIDTH  core byte address
- c_wdata  in  DATA_WIDTH  core write data
- c_gnt  out  1  core access issued this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_WIDTH  core read data
- d_req, d_we, d_be, d_addr, d_wdata  in  as core  debug request signals
- d_lock  in  1  debug requests back-to-back priority
- d_gnt, d_rvalid  out  1  debug grant / read valid
- d_rdata  out  DATA_WIDTH  debug read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory byte address; word indexing is done inside memory
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  synchronous read data, valid the cycle after mem_en && !mem_we

Behaviour:
- **Grant logic.** Grant decision is combinational from the requests and registered state. c_gnt and d_gnt are mutually exclusive. mem_en = c_gnt | d_gnt.
- **Address/data mux.** mem_* carry the granted requester's signals. When idle: mem_we=0, mem_be=0; mem_addr and mem_wdata are don't-care, but driven to 0.
- **Arbitration:**
  - Only one request active: grant it the same cycle.
  - Both active and d_lock=0: round-robin; grant the requester not granted most recently (last_owner register).
  - Both active and d_lock=1: grant debug, unless lock_cnt == MAX_LOCK, in which case grant core for that cycle.
- **lock_cnt:**
  - Increments on each debug grant while d_lock=1, saturating at MAX_LOCK.
  - Clears on any core grant, or when d_lock=0.
- **Read return:**
  - A registered rd_owner (none/core/debug) records each granted read.
  - Next cycle, the matching rvalid pulses 1 cycle and its rdata = mem_rdata. The other requester's rdata holds its previous value.
  - Writes produce no rvalid.
- **Throughput:** back-to-back grants are allowed every cycle. A read issued in cycle N and a grant in cycle N+1 are independent.
- **Request semantics:**
  - A requester may drop req before its grant without penalty.
  - A request remains pending while unfavoured; its address must stay stable.
- **Reset (synchronous, active-high):**
  - Registers: last_owner=debug (core wins first tie), lock_cnt=0, rd_owner=none.
  - Outputs: c_rvalid=0, d_rvalid=0, c_rdata=0, d_rdata=0.
  - Grants are forced 0 while reset is high.
  - A read issued the cycle before reset asserts returns no rvalid.
- **Boundary cases:**
  - Simultaneous grant and rvalid to the same requester is legal.
  - MAX_LOCK=0 means d_lock never overrides round-robin.

Test Plan:
1. **Core-only read.** Mem[0]=32'h003160b3; c_req=1, c_addr=0 -> c_gnt same cycle; next cycle c_rvalid=1, c_rdata=32'h003160b3, d_rvalid=0.
2. **Debug write then core read.** d_req write addr 8, wdata 32'hf0f0f0f0, be 4'hf -> d_gnt. Then c_req read addr 8 -> c_rdata=32'hf0f0f0f0.
3. **Round-robin tie.** Both request reads continuously from reset -> grants alternate C,D,C,D. Each rvalid routes to the correct port with its own address's data.
4. **Lock starvation guard.** MAX_LOCK=8, d_lock=1, both requesting -> 8 consecutive d_gnt, then 1 c_gnt, then debug again.
5. **Byte write.** Mem[4]=32'h0b0b0b0b; core write be=4'b0010, wdata=32'h0000aa00 -> read back 32'h0b0baa0b.
6. **Reset mid-read.** Grant core read, assert reset next cycle -> c_rvalid stays 0, all grants 0 during reset. After release, first tie goes to core.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the core, debug and memory-side signals of the shared memory arbiter.
// The arbiter binds to the slave modport; requesters and memory models use master.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // core requester
  logic                  c_req;
  logic                  c_we;
  logic [BE_WIDTH-1:0]   c_be;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_gnt;
  logic                  c_rvalid;
  logic [DATA_WIDTH-1:0] c_rdata;

  // debug / loader requester
  logic                  d_req;
  logic                  d_we;
  logic [BE_WIDTH-1:0]   d_be;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_lock;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  // single-port memory
  logic                  mem_en;
  logic                  mem_we;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_be, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_be, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between the core and the debug/loader port,
// with round-robin ties, a bounded debug lock, and 1-cycle read-data return routing.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 8
) (
  input logic        clk,
  input logic        reset,
  mem_arbiter_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int LOCK_W   = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);
  // A zero limit disables the lock entirely rather than forcing core every cycle.
  localparam bit LOCK_ENABLED = (MAX_LOCK > 0);

  typedef enum logic {
    OWNER_CORE  = 1'b0,
    OWNER_DEBUG = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    RD_NONE  = 2'd0,
    RD_CORE  = 2'd1,
    RD_DEBUG = 2'd2
  } rd_owner_t;

  owner_t                last_owner_reg, last_owner_next;
  rd_owner_t             rd_owner_reg, rd_owner_next;
  logic [LOCK_W-1:0]     lock_cnt_reg, lock_cnt_next;
  logic [DATA_WIDTH-1:0] c_hold_reg, c_hold_next;
  logic [DATA_WIDTH-1:0] d_hold_reg, d_hold_next;

  logic c_gnt_int;
  logic d_gnt_int;
  logic c_rvalid_int;
  logic d_rvalid_int;

  // Grant decision: purely combinational from requests and registered state.
  always_comb begin
    c_gnt_int = 1'b0;
    d_gnt_int = 1'b0;
    if (!reset) begin
      if (bus.c_req && !bus.d_req) begin
        c_gnt_int = 1'b1;
      end else if (bus.d_req && !bus.c_req) begin
        d_gnt_int = 1'b1;
      end else if (bus.c_req && bus.d_req) begin
        if (LOCK_ENABLED && bus.d_lock) begin
          if (lock_cnt_reg == LOCK_MAX) begin
            c_gnt_int = 1'b1;
          end else begin
            d_gnt_int = 1'b1;
          end
        end else if (last_owner_reg == OWNER_DEBUG) begin
          c_gnt_int = 1'b1;
        end else begin
          d_gnt_int = 1'b1;
        end
      end
    end
  end

  // Memory-side mux; idle cycles drive zeros so nothing stray reaches the RAM.
  always_comb begin
    bus.mem_en    = c_gnt_int | d_gnt_int;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (c_gnt_int) begin
      bus.mem_we    = bus.c_we;
      bus.mem_be    = bus.c_we ? bus.c_be : '0;
      bus.mem_addr  = bus.c_addr;
      bus.mem_wdata = bus.c_wdata;
    end else if (d_gnt_int) begin
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_we ? bus.d_be : '0;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  // Next-state for the round-robin pointer, lock counter and read owner.
  always_comb begin
    last_owner_next = last_owner_reg;
    lock_cnt_next   = lock_cnt_reg;
    rd_owner_next   = RD_NONE;

    if (c_gnt_int) begin
      last_owner_next = OWNER_CORE;
    end else if (d_gnt_int) begin
      last_owner_next = OWNER_DEBUG;
    end

    if (c_gnt_int || !bus.d_lock || !LOCK_ENABLED) begin
      lock_cnt_next = '0;
    end else if (d_gnt_int && (lock_cnt_reg != LOCK_MAX)) begin
      lock_cnt_next = lock_cnt_reg + 1'b1;
    end

    if (c_gnt_int && !bus.c_we) begin
      rd_owner_next = RD_CORE;
    end else if (d_gnt_int && !bus.d_we) begin
      rd_owner_next = RD_DEBUG;
    end
  end

  // A read in flight when reset rises must not surface as rvalid.
  assign c_rvalid_int = !reset && (rd_owner_reg == RD_CORE);
  assign d_rvalid_int = !reset && (rd_owner_reg == RD_DEBUG);

  always_comb begin
    c_hold_next = c_hold_reg;
    d_hold_next = d_hold_reg;
    if (c_rvalid_int) begin
      c_hold_next = bus.mem_rdata;
    end
    if (d_rvalid_int) begin
      d_hold_next = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_reg <= OWNER_DEBUG;
      lock_cnt_reg   <= '0;
      rd_owner_reg   <= RD_NONE;
      c_hold_reg     <= '0;
      d_hold_reg     <= '0;
    end else begin
      last_owner_reg <= last_owner_next;
      lock_cnt_reg   <= lock_cnt_next;
      rd_owner_reg   <= rd_owner_next;
      c_hold_reg     <= c_hold_next;
      d_hold_reg     <= d_hold_next;
    end
  end

  // Read data passes straight through on the return cycle, otherwise holds the last value.
  assign bus.c_gnt    = c_gnt_int;
  assign bus.d_gnt    = d_gnt_int;
  assign bus.c_rvalid = c_rvalid_int;
  assign bus.d_rvalid = d_rvalid_int;
  assign bus.c_rdata  = reset ? '0 : (c_rvalid_int ? bus.mem_rdata : c_hold_reg);
  assign bus.d_rdata  = reset ? '0 : (d_rvalid_int ? bus.mem_rdata : d_hold_reg);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small byte-enabled synchronous RAM model.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  logic preload;
  int   tests_run;
  int   tests_failed;

  logic [31:0] ram [0:15];

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_LOCK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write with byte enables, read data registered one cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        ram[i] <= 32'h1000_0000 + i;
      end
      ram[0] <= 32'h003160b3;
      ram[1] <= 32'h0b0b0b0b;
      bus.mem_rdata <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be[b]) ram[bus.mem_addr[5:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr[5:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b1;
    preload = 1'b1;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_be = 4'h0; bus.c_addr = 32'h0; bus.c_wdata = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h4; bus.d_wdata = 32'h0;
    bus.d_lock = 1'b0;

    // Reset state with both requesting
    settle();
    chk("rst_c_gnt", {31'b0, bus.c_gnt}, 32'd0);
    chk("rst_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
    chk("rst_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
    chk("rst_c_rdata", bus.c_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    next();
    preload = 1'b0;
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    next();
    reset = 1'b0;

    // 1: core-only read of word 0
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h0;
    settle();
    chk("t1_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
    chk("t1_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
    chk("t1_mem_en", {31'b0, bus.mem_en}, 32'd1);
    chk("t1_mem_we", {31'b0, bus.mem_we}, 32'd0);
    next();
    bus.c_req = 1'b0;
    settle();
    chk("t1_c_rvalid", {31'b0, bus.c_rvalid}, 32'd1);
    chk("t1_c_rdata", bus.c_rdata, 32'h003160b3);
    chk("t1_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
    chk("t1_idle_mem_en", {31'b0, bus.mem_en}, 32'd0);

    // 2: debug write of addr 8, then core read back
    next();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'hf0f0f0f0; bus.d_be = 4'hf;
    settle();
    chk("t2_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
    chk("t2_mem_we", {31'b0, bus.mem_we}, 32'd1);
    chk("t2_mem_be", {28'b0, bus.mem_be}, 32'h0000000f);
    chk("t2_mem_wdata", bus.mem_wdata, 32'hf0f0f0f0);
    chk("t2_mem_addr", bus.mem_addr, 32'h8);
    chk("t2_c_rdata_hold", bus.c_rdata, 32'h003160b3);
    next();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h8;
    settle();
    chk("t2_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
    chk("t2_wr_no_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
    next();
    bus.c_req = 1'b0;
    settle();
    chk("t2_c_rvalid", {31'b0, bus.c_rvalid}, 32'd1);
    chk("t2_c_rdata", bus.c_rdata, 32'hf0f0f0f0);

    // 5: byte write into word 1, then read back
    next();
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h4; bus.c_be = 4'b0010; bus.c_wdata = 32'h0000aa00;
    settle();
    chk("t5_c_gnt_wr", {31'b0, bus.c_gnt}, 32'd1);
    chk("t5_mem_be", {28'b0, bus.mem_be}, 32'h00000002);
    next();
    bus.c_we = 1'b0;
    settle();
    chk("t5_c_gnt_rd", {31'b0, bus.c_gnt}, 32'd1);
    chk("t5_wr_no_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
    next();
    bus.c_req = 1'b0;
    settle();
    chk("t5_c_rdata", bus.c_rdata, 32'h0b0baa0b);

    // 4: lock starvation guard, 8 debug grants then one forced core slot
    next();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4; bus.d_lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("t4_lock_d_gnt%0d", i), {31'b0, bus.d_gnt}, 32'd1);
      chk($sformatf("t4_lock_c_gnt%0d", i), {31'b0, bus.c_gnt}, 32'd0);
      next();
    end
    settle();
    chk("t4_forced_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
    chk("t4_forced_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
    next();
    settle();
    chk("t4_relock_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
    chk("t4_c_rvalid", {31'b0, bus.c_rvalid}, 32'd1);
    chk("t4_c_rdata", bus.c_rdata, 32'h003160b3);
    chk("t4_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);

    // 6: reset right after a granted core read
    next();
    bus.d_req = 1'b0; bus.d_lock = 1'b0;
    settle();
    chk("t6_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
    chk("t6_d_rvalid", {31'b0, bus.d_rvalid}, 32'd1);
    chk("t6_d_rdata", bus.d_rdata, 32'h0b0baa0b);
    next();
    reset = 1'b1;
    bus.d_req = 1'b1;
    bus.c_addr = 32'h10; bus.d_addr = 32'h14;
    settle();
    chk("t6_rst_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
    chk("t6_rst_c_gnt", {31'b0, bus.c_gnt}, 32'd0);
    chk("t6_rst_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
    chk("t6_rst_c_rdata", bus.c_rdata, 32'h0);
    next();
    settle();
    chk("t6_rst2_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
    next();
    reset = 1'b0;

    // 3: round-robin from reset, core wins first tie
    settle();
    chk("t3_c0_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
    chk("t3_c0_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
    chk("t3_c0_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
    chk("t3_c0_mem_addr", bus.mem_addr, 32'h10);
    next();
    settle();
    chk("t3_c1_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
    chk("t3_c1_mem_addr", bus.mem_addr, 32'h14);
    chk("t3_c1_c_rvalid", {31'b0, bus.c_rvalid}, 32'd1);
    chk("t3_c1_c_rdata", bus.c_rdata, 32'h10000004);
    chk("t3_c1_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
    next();
    settle();
    chk("t3_c2_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
    chk("t3_c2_d_rvalid", {31'b0, bus.d_rvalid}, 32'd1);
    chk("t3_c2_d_rdata", bus.d_rdata, 32'h10000005);
    chk("t3_c2_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
    next();
    settle();
    chk("t3_c3_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
    chk("t3_c3_c_rvalid", {31'b0, bus.c_rvalid}, 32'd1);
    chk("t3_c3_c_rdata", bus.c_rdata, 32'h10000004);
    next();
    bus.c_req = 1'b0; bus.d_req = 1'b0;
    settle();
    chk("t3_end_d_rdata", bus.d_rdata, 32'h10000005);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
